// File: rtl/seg_pkg.sv
// Shared definitions for the four-digit seven-segment scanner: digit count,
// display record layout, the segment code table and leading-zero helper.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dots;
    logic        lzb;
  } disp_t;

  // Active-low codes for hex 0..F; bit 7 is the dot position and stays 1 here.
  localparam logic [7:0] SEG_CODES [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Digit 0 is never a leading zero; higher digits are when they and every
  // digit to their left are zero.
  function automatic logic lead_zero(input logic [15:0] value, input logic [1:0] index);
    logic z;
    z = 1'b0;
    case (index)
      2'd1:    z = (value[15:4] == '0);
      2'd2:    z = (value[15:8] == '0);
      2'd3:    z = (value[15:12] == '0);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern (g..a).
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  logic [7:0] code;

  assign code = SEG_CODES[nibble];
  assign segs = code[6:0];

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed four-digit display driver with a one-deep pending buffer
// that is promoted to the displayed value only at frame boundaries.
module seg_scan
  import seg_pkg::*;
#(
  parameter int PRESCALE = 4096,
  parameter int BLANK    = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           in_value,
  input  logic [3:0]            in_dots,
  input  logic                  in_lzb,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] dig,
  output logic                  frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

  logic [CW-1:0]         cnt;
  logic [1:0]            idx;
  disp_t                 active;
  disp_t                 pend;
  logic                  pend_full;
  logic                  tc;
  logic                  boundary;
  logic                  accept;
  logic                  in_blank;
  logic                  lz;
  logic [3:0]            nib;
  logic [6:0]            dec;
  logic [7:0]            seg_next;
  logic [NUM_DIGITS-1:0] dig_next;

  assign tc       = (cnt == CNT_MAX);
  assign boundary = tc && (idx == 2'd3);
  assign in_ready = ~pend_full;
  assign accept   = in_valid && in_ready;

  generate
    if (BLANK == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt < CW'(BLANK));
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (tc) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Accept and promotion never coincide: accept needs an empty pending buffer,
  // so a value taken on the boundary cycle waits a full frame.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      active    <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
    end else if (boundary && pend_full) begin
      active    <= pend;
      pend_full <= 1'b0;
    end else if (accept) begin
      pend      <= '{value: in_value, dots: in_dots, lzb: in_lzb};
      pend_full <= 1'b1;
    end
  end

  assign nib = active.value[{idx, 2'b00} +: 4];
  assign lz  = active.lzb && lead_zero(active.value, idx);

  seg_decode u_decode (
    .nibble (nib),
    .segs   (dec)
  );

  always_comb begin
    seg_next = 8'hFF;
    dig_next = '0;
    if (!in_blank) begin
      dig_next = NUM_DIGITS'(1) << idx;
      seg_next = {~active.dots[idx], (lz ? 7'h7F : dec)};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      seg        <= 8'hFF;
      dig        <= '0;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_next;
      dig        <= dig_next;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan with PRESCALE=8, BLANK=2: accepted values are
// queued with the boundary at which they must appear, a monitor checks every cycle.
module tb_seg_scan;

  localparam int PS    = 8;
  localparam int BL    = 2;
  localparam int FRAME = 4 * PS;

  localparam logic [6:0] REF_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    logic [15:0] v;
    logic [3:0]  d;
    logic        l;
    int          eff;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_value = 16'h0;
  logic [3:0]  in_dots = 4'h0;
  logic        in_lzb = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame_done;

  int   tests = 0;
  int   fails = 0;
  int   gcyc = 0;
  int   base = 0;
  int   last_acc = -1;
  int   last_eff = -1;
  exp_t q[$];
  exp_t mon_active;

  seg_scan #(.PRESCALE(PS), .BLANK(BL)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .in_dots    (in_dots),
    .in_lzb     (in_lzb),
    .seg        (seg),
    .dig        (dig),
    .frame_done (frame_done)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) gcyc <= gcyc + 1;

  function automatic int cur_t();
    return gcyc - base;
  endfunction

  // First frame boundary strictly after cycle x.
  function automatic int next_boundary(input int x);
    return ((x + 1) / FRAME) * FRAME + FRAME - 1;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s t=%0d: got %h expected %h", name, cur_t(), act, exp);
    end
  endtask

  always @(negedge CLK) begin : monitor
    int t, s, ix;
    logic [15:0] sh;
    logic [7:0]  e_seg;
    logic [3:0]  e_dig;
    logic        e_fd, e_rdy;
    if (RST) begin
      mon_active = '{v: 16'h0, d: 4'h0, l: 1'b0, eff: 0};
      check_output("reset_out", {19'h0, seg, dig, frame_done}, {19'h0, 8'hFF, 4'h0, 1'b0});
    end else begin
      t = cur_t();
      s = t - 1;
      if (s >= 0 && q.size() > 0 && q[0].eff < s) mon_active = q.pop_front();
      e_seg = 8'hFF;
      e_dig = 4'h0;
      if (s >= 0 && (s % PS) >= BL) begin
        ix    = (s / PS) % 4;
        sh    = mon_active.v >> (4 * ix);
        e_dig = 4'b0001 << ix;
        e_seg = {~mon_active.d[ix],
                 (mon_active.l && ix > 0 && sh == 16'h0) ? 7'h7F : REF_SEG[sh[3:0]] | 7'h00};
        e_seg[7] = ~mon_active.d[ix];
      end
      e_fd  = (s >= 0) && ((s % FRAME) == FRAME - 1);
      e_rdy = !(last_acc < t && t <= last_eff);
      check_output("scan_out", {18'h0, seg, dig, frame_done, in_ready},
                   {18'h0, e_seg, e_dig, e_fd, e_rdy});
    end
  end

  task automatic release_reset();
    @(posedge CLK);
    #1;
    RST      = 1'b0;
    base     = gcyc;
    last_acc = -1;
    last_eff = -1;
    q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Hold the offer until the model says the pending buffer is free; then
  // scramble the inputs to show they no longer matter.
  task automatic apply_stimulus(input logic [15:0] v, input logic [3:0] d, input logic l);
    int t;
    bit done;
    in_value = v;
    in_dots  = d;
    in_lzb   = l;
    in_valid = 1'b1;
    done     = 1'b0;
    for (int k = 0; k < 4 * FRAME && !done; k++) begin
      t = cur_t();
      if (t > last_eff) begin
        last_acc = t;
        last_eff = next_boundary(t);
        q.push_back('{v: v, d: d, l: l, eff: last_eff});
        done = 1'b1;
      end
      @(posedge CLK);
      #1;
    end
    if (!done) check_output("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_value = 16'($urandom);
    in_dots  = 4'($urandom);
    in_lzb   = 1'($urandom);
  endtask

  task automatic idle_until_phase(input int ph);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 4 * FRAME && !hit; k++) begin
      if ((cur_t() % FRAME) == ph && cur_t() > last_eff) hit = 1'b1;
      else idle(1);
    end
    if (!hit) check_output("phase_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [15:0] mask;
    idle(3);
    release_reset();
    idle(70);

    apply_stimulus(16'h12AF, 4'b0010, 1'b0);
    idle(70);

    idle_until_phase(5);
    apply_stimulus(16'h3456, 4'b1000, 1'b0);
    apply_stimulus(16'hBEEF, 4'b0101, 1'b0);
    idle(80);

    apply_stimulus(16'h0050, 4'b0000, 1'b1);
    idle(40);
    apply_stimulus(16'h0000, 4'b0000, 1'b1);
    idle(70);
    apply_stimulus(16'h0000, 4'b1111, 1'b1);
    idle(40);

    idle_until_phase(FRAME - 1);
    apply_stimulus(16'hC0DE, 4'b0001, 1'b0);
    idle(70);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0:       mask = 16'hFFFF;
        1:       mask = 16'h0FFF;
        2:       mask = 16'h00FF;
        3:       mask = 16'h000F;
        default: mask = 16'h0000;
      endcase
      idle($urandom_range(0, 40));
      apply_stimulus(16'($urandom) & mask, 4'($urandom), 1'($urandom));
    end
    idle(70);

    idle_until_phase(2);
    apply_stimulus(16'h9876, 4'b0110, 1'b0);
    while ((cur_t() % PS) != 5) idle(1);
    #3;
    RST = 1'b1;
    #1;
    check_output("async_reset", {20'h0, seg, dig}, {20'h0, 8'hFF, 4'h0});
    idle(3);
    release_reset();
    idle(70);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter PRESCALE, default 4096, clock cycles per digit slot (>= 2).
REQ-002 SHALL have parameter BLANK, default 64, blanked cycles at the start of each slot (0 <= BLANK < PRESCALE).
REQ-003 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  new display value offered.
REQ-006 SHALL have port in_ready  output  1  pending buffer empty, value can be accepted.
REQ-007 SHALL have port in_value  input  16  four hex nibbles; nibble 0 = [3:0] = rightmost digit.
REQ-008 SHALL have port in_dots  input  4  per-digit decimal point, bit i = digit i.
REQ-009 SHALL have port in_lzb  input  1  leading-zero blanking enable for this value.
REQ-010 SHALL have port seg  output  8  active-low segments, [6:0] = g..a, [7] = dot.
REQ-011 SHALL have port dig  output  4  active-high one-hot digit enable.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 SHALL count a prescaler 0..PRESCALE-1 and advance the digit index 0->1->2->3->0 on terminal count.
REQ-014 SHALL define a frame as four slots; the frame boundary is the cycle the index wraps 3->0.
REQ-015 SHALL, during the first BLANK cycles of each slot, drive dig=4'b0000 and seg=8'hFF; BLANK=0 disables blanking.
REQ-016 SHALL, for the rest of the slot, drive dig one-hot at the current index and seg = decoded active nibble.
REQ-017 SHALL register seg and dig: one cycle latency from counter state to outputs; at no cycle are two dig bits high.
REQ-018 SHALL decode nibbles 0-F to [6:0]: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E (hex, bit7 shown as 1).
REQ-019 SHALL set seg[7] = ~dots[index] of the active value.
REQ-020 SHALL accept in_value/in_dots/in_lzb into a pending buffer when in_valid && in_ready; in_ready deasserts the next cycle.
REQ-021 SHALL copy pending to active at the frame boundary if pending is full, clear pending, and reassert in_ready the following cycle.
REQ-022 SHALL, on accept in the boundary cycle itself, hold that value in pending until the next boundary.
REQ-023 SHALL hold in_value stable-insensitive: after accept, input changes have no effect.
REQ-024 SHALL pulse frame_done for exactly one cycle at every boundary, whether or not active was updated.
REQ-025 SHALL, when active lzb=1, blank (seg[6:0]=7'h7F) digit i>0 if nibble i and all higher nibbles are zero; digit 0 never blanked; dot still honoured.

Reset
REQ-026 SHALL, while RST high, force seg=8'hFF, dig=0, frame_done=0, prescaler=0, index=0, active value/dots/lzb=0, pending empty.
REQ-027 SHALL drive in_ready=1 from the first cycle after RST deasserts.
REQ-028 SHALL discard pending and active contents on reset asserted mid-frame; first frame after reset shows 0000.

Structure
REQ-029 SHALL place the 16-entry segment code table and the digit count (4) in shared package seg_pkg.
REQ-030 SHALL implement the nibble-to-segment decode as combinational sub-module seg_decode; prescaler, scan index, handshake and buffers stay in seg_scan.

Verification (PRESCALE=8, BLANK=2)
REQ-031 Reset release, no input -> in_ready=1; per slot 2 cycles dig=0/seg=FF then 6 cycles seg=C0, dig 0001,0010,0100,1000; frame_done every 32 cycles.
REQ-032 Load 16'h12AF, dots 4'b0010, lzb=0 -> after next boundary slots show 8E, 08, A4, F9 on digits 0..3.
REQ-033 Two back-to-back offers before a boundary -> first accepted, in_ready=0 holding second until boundary+1, second shown one frame later.
REQ-034 Load 16'h0050 lzb=1 -> digit0 C0, digit1 92, digits 2,3 FF; load 16'h0000 lzb=1 -> only digit0 C0.
REQ-035 Offer accepted exactly on boundary cycle -> active unchanged that frame, new value from following boundary.
REQ-036 Assert RST mid-slot with pending full -> seg=FF, dig=0 asynchronously; after release, display 0000 and in_ready=1.
